// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences requests into the 32x32 signed Booth core and corrects its product into RISC-V MUL/MULH/MULHSU/MULHU results.
// Optional product cache enabled by defining MUL_CACHE_EN.
module mul_ctrl #(
    parameter int CORE_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        core_load,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    input  logic [31:0] core_mh,
    input  logic [31:0] core_ml
);

    localparam int CW = $clog2(CORE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    y_q, y_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    resp_data_q, resp_data_d;
    logic           resp_valid_q, resp_valid_d;
    logic           req_ready_q, req_ready_d;
    logic           core_load_q, core_load_d;
    logic           hit_s;
    logic [31:0]    src_mh_s;
    logic [31:0]    src_ml_s;

    // Unsigned high words are recovered from the signed product by adding back the operand weights.
    function automatic logic [31:0] fix_result(
        input logic [1:0]  op,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] mh,
        input logic [31:0] ml
    );
        logic [31:0] add_x;
        logic [31:0] add_y;
        add_x = y[31] ? x : 32'd0;
        add_y = x[31] ? y : 32'd0;
        case (op)
            2'b00:   fix_result = ml;
            2'b01:   fix_result = mh;
            2'b10:   fix_result = mh + add_x;
            2'b11:   fix_result = mh + add_x + add_y;
            default: fix_result = ml;
        endcase
    endfunction

`ifdef MUL_CACHE_EN
    logic [31:0] cmh_q, cmh_d;
    logic [31:0] cml_q, cml_d;
    logic [31:0] cx_q, cx_d;
    logic [31:0] cy_q, cy_d;
    logic        cv_q, cv_d;
    logic        hit_q, hit_d;

    assign hit_s    = cv_q && (req_x == cx_q) && (req_y == cy_q);
    assign src_mh_s = hit_q ? cmh_q : core_mh;
    assign src_ml_s = hit_q ? cml_q : core_ml;

    // Cache next state: capture the raw product at FIX of every real core operation.
    always_comb begin
        cmh_d = cmh_q;
        cml_d = cml_q;
        cx_d  = cx_q;
        cy_d  = cy_q;
        cv_d  = cv_q;
        hit_d = hit_q;
        if (state_q == IDLE && req_valid) begin
            hit_d = hit_s;
        end else if (state_q == FIX && !hit_q) begin
            cmh_d = core_mh;
            cml_d = core_ml;
            cx_d  = x_q;
            cy_d  = y_q;
            cv_d  = 1'b1;
        end else begin
            hit_d = hit_q;
        end
    end

    // Cache registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmh_q <= 32'd0;
            cml_q <= 32'd0;
            cx_q  <= 32'd0;
            cy_q  <= 32'd0;
            cv_q  <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            cmh_q <= cmh_d;
            cml_q <= cml_d;
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            cv_q  <= cv_d;
            hit_q <= hit_d;
        end
    end
`else
    assign hit_s    = 1'b0;
    assign src_mh_s = core_mh;
    assign src_ml_s = core_ml;
`endif

    // Next-state and registered-output logic of the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    x_d     = req_x;
                    y_d     = req_y;
                    op_d    = req_op;
                    state_d = hit_s ? FIX : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                cnt_d   = {CW{1'b0}};
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(CORE_LAT - 1)) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                resp_data_d = fix_result(op_q, x_q, y_q, src_mh_s, src_ml_s);
                state_d     = OUT;
            end
            OUT: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered from the upcoming state so they line up with it.
        req_ready_d  = (state_d == IDLE);
        core_load_d  = (state_d == LOAD);
        resp_valid_d = (state_d == OUT);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= 32'd0;
            y_q          <= 32'd0;
            op_q         <= 2'd0;
            cnt_q        <= {CW{1'b0}};
            resp_data_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            core_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            core_load_q  <= core_load_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign core_load  = core_load_q;
    assign core_x     = x_q;
    assign core_y     = y_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed testbench for mul_ctrl with a behavioural Booth-core model; core outputs are wrong until CORE_LAT edges after load.
module tb_mul_ctrl;

    localparam int CORE_LAT = 5;
`ifdef MUL_CACHE_EN
    localparam int HIT_LAT   = 1;
    localparam int HIT_LOADS = 0;
`else
    localparam int HIT_LAT   = 7;
    localparam int HIT_LOADS = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_x = 32'd0;
    logic [31:0] req_y = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        core_load;
    logic [31:0] core_x;
    logic [31:0] core_y;
    logic [31:0] core_mh;
    logic [31:0] core_ml;

    int tests = 0;
    int fails = 0;

    mul_ctrl #(.CORE_LAT(CORE_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .core_load  (core_load),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_mh    (core_mh),
        .core_ml    (core_ml)
    );

    always #5 clk = ~clk;

    // Core model: y sampled at load, x used live; the product is inverted until it is final.
    logic [31:0] cap_y = 32'd0;
    int          mcnt = 0;
    logic [63:0] prod;
    always @(posedge clk) begin
        if (core_load) begin
            cap_y <= core_y;
            mcnt  <= 0;
        end else if (mcnt < CORE_LAT) begin
            mcnt <= mcnt + 1;
        end
    end
    always_comb begin
        prod = 64'(longint'($signed(core_x)) * longint'($signed(cap_y)));
        if (mcnt < CORE_LAT) prod = ~prod;
        core_mh = prod[63:32];
        core_ml = prod[31:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for acceptance edge E0, then scramble the request inputs.
    task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        int t;
        req_valid = 1'b1;
        req_op    = op;
        req_x     = x;
        req_y     = y;
        t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
        tick();
        req_valid = 1'b0;
        req_x     = $urandom;
        req_y     = $urandom;
        req_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_resp(output int lat, output int loads);
        lat   = 0;
        loads = int'(core_load);
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
            loads += int'(core_load);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                          input int exp_loads);
        int lat;
        int loads;
        send(op, x, y);
        wait_resp(lat, loads);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_loads"}, 32'(loads), 32'(exp_loads));
        chk({tag, "_data"}, resp_data, exp);
        tick();
        chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin : main
        int lat;
        int loads;
        int seen;

        // Reset and idle behaviour.
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        seen = int'(core_load);
        repeat (5) begin
            tick();
            seen += int'(core_load);
        end
        chk("idle_no_load", 32'(seen), 32'd0);

        // All-ones operands through every op.
        run_op("ff_mul",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 7, 1);
        run_op("ff_mulh",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, HIT_LAT, HIT_LOADS);
        run_op("ff_mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, HIT_LAT, HIT_LOADS);
        run_op("ff_mulhu",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, HIT_LAT, HIT_LOADS);

        // Most-negative operands.
        run_op("m_mulhu",  2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 7, 1);
        run_op("m_mulh",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, HIT_LAT, HIT_LOADS);
        run_op("m_mulhsu", 2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, HIT_LAT, HIT_LOADS);

        // Backpressure: 1234*5678 = 7006652 = 0x006AE9BC held while a second request waits.
        resp_ready = 1'b0;
        send(2'b00, 32'd1234, 32'd5678);
        wait_resp(lat, loads);
        chk("bp_lat", 32'(lat), 32'd7);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_x     = 32'd9;
        req_y     = 32'd9;
        for (int i = 0; i < 10; i++) begin
            chk("bp_data", resp_data, 32'h006AE9BC);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_after_hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
        send(2'b00, 32'd9, 32'd9);
        wait_resp(lat, loads);
        chk("bp2_lat", 32'(lat), 32'd7);
        chk("bp2_data", resp_data, 32'd81);
        tick();

        // Reset during RUN drops the operation.
        send(2'b00, 32'd5, 32'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rr_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rr_core_load", {31'd0, core_load}, 32'd0);
        seen = 0;
        repeat (15) begin
            tick();
            seen += int'(resp_valid);
        end
        chk("rr_no_resp", 32'(seen), 32'd0);
        run_op("rr_mul", 2'b00, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 7, 1);

`ifdef MUL_CACHE_EN
        // Cached product reuse, then invalidation by reset.
        run_op("c_mul",   2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 7, 1);
        run_op("c_mulh",  2'b01, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        run_op("c_mulhu", 2'b11, 32'd7, 32'hFFFFFFFF, 32'h00000006, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_op("c_after_rst", 2'b01, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
